// File: rtl/timer_light_pkg.sv
// Shared types for the timer light array: channel state encoding and a reload-range helper.
// Latency: none (types and constants only).
// Backpressure: none.
package timer_light_pkg;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } tl_state_e;

    // True when reload value t can be held in a w-bit counter.
    function automatic bit tl_reload_fits(input int t, input int w);
        if (t < 0)
            return 1'b0;
        if (w >= 62)
            return 1'b1;
        return longint'(t) < (longint'(1) << w);
    endfunction

endpackage

// File: rtl/timer_light_array_if.sv
// Per-channel button, cancel and lamp bundle for timer_light_array; warn lane exists with TIMER_LIGHT_WARN_EN.
// Latency: none (wiring only).
// Backpressure: none; every lane is a level sampled each cycle.
interface timer_light_array_if #(
    parameter int N = 4
);
    logic [N-1:0] push_btn;
    logic [N-1:0] cancel;
    logic [N-1:0] light;
    logic         any_on;
`ifdef TIMER_LIGHT_WARN_EN
    logic [N-1:0] warn;
`endif

    modport master (
        output push_btn,
        output cancel,
        input  light,
`ifdef TIMER_LIGHT_WARN_EN
        input  warn,
`endif
        input  any_on
    );

    modport slave (
        input  push_btn,
        input  cancel,
        output light,
`ifdef TIMER_LIGHT_WARN_EN
        output warn,
`endif
        output any_on
    );

endinterface

// File: rtl/timer_light_ch.sv
// One auto-off light channel: OFF/ON FSM plus W-bit down-counter; warn output with TIMER_LIGHT_WARN_EN.
// Latency: push in OFF lights the lamp from the next edge for T+1 cycles; outputs are registered-state only.
// Backpressure: none; push_btn/cancel sampled every cycle, cancel beats push.
module timer_light_ch
    import timer_light_pkg::*;
#(
    parameter int W      = 8,
    parameter int T      = 20,
    parameter int RETRIG = 1
`ifdef TIMER_LIGHT_WARN_EN
    ,
    parameter int WARN   = 3
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic push_btn,
    input  logic cancel,
`ifdef TIMER_LIGHT_WARN_EN
    output logic warn,
`endif
    output logic light
);

    localparam logic [W-1:0] T_LD = W'(T);

    tl_state_e      state;
    tl_state_e      state_nxt;
    logic [W-1:0]   tmr;
    logic [W-1:0]   tmr_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ON;
            tmr   <= T_LD;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
        end
    end

    // Counter only moves while ON and nonzero, so it can never wrap.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        case (state)
            ON: begin
                if (cancel) begin
                    state_nxt = OFF;
                end else if (push_btn && (RETRIG != 0)) begin
                    tmr_nxt = T_LD;
                end else if (tmr == '0) begin
                    state_nxt = OFF;
                end else begin
                    tmr_nxt = tmr - W'(1);
                end
            end
            OFF: begin
                if (!cancel && push_btn) begin
                    state_nxt = ON;
                    tmr_nxt   = T_LD;
                end
            end
            default: begin
                state_nxt = OFF;
            end
        endcase
    end

    assign light = (state == ON);

`ifdef TIMER_LIGHT_WARN_EN
    assign warn = (state == ON) && (32'(tmr) < 32'($unsigned(WARN)));
`endif

endmodule

// File: rtl/timer_light_array.sv
// N independent auto-off light channels plus an any-lit flag; TIMER_LIGHT_WARN_EN adds WARN and a per-channel warn lane.
// Latency: one edge from push to lamp; any_on follows the registered lamps with no added delay.
// Backpressure: none; all channels sample their inputs every cycle.
module timer_light_array
    import timer_light_pkg::*;
#(
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int T      = 20,
    parameter int RETRIG = 1
`ifdef TIMER_LIGHT_WARN_EN
    ,
    parameter int WARN   = 3
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    timer_light_array_if.slave   bus
);

    if (N < 1 || W < 1 || !tl_reload_fits(T, W)) begin : g_bad_cfg
        $fatal(1, "timer_light_array: illegal parameters N=%0d W=%0d T=%0d", N, W, T);
    end

    logic [N-1:0] light_w;
`ifdef TIMER_LIGHT_WARN_EN
    logic [N-1:0] warn_w;
`endif

    for (genvar i = 0; i < N; i++) begin : g_ch
        timer_light_ch #(
            .W      (W),
            .T      (T),
`ifdef TIMER_LIGHT_WARN_EN
            .WARN   (WARN),
`endif
            .RETRIG (RETRIG)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .push_btn (bus.push_btn[i]),
            .cancel   (bus.cancel[i]),
`ifdef TIMER_LIGHT_WARN_EN
            .warn     (warn_w[i]),
`endif
            .light    (light_w[i])
        );
    end

    assign bus.light  = light_w;
    assign bus.any_on = |light_w;
`ifdef TIMER_LIGHT_WARN_EN
    assign bus.warn   = warn_w;
`endif

endmodule

// File: tb/tb_timer_light_array.sv
// Bench for timer_light_array: four configurations share one random stimulus stream and are compared
// against a deadline-based model each cycle; warn is compared when TIMER_LIGHT_WARN_EN is defined.
module tb_timer_light_array;
    import timer_light_pkg::*;

    localparam int NC = 4;
    localparam int NCFG = 4;
    localparam int TV[NCFG] = '{5, 5, 0, 15};
    localparam int RV[NCFG] = '{1, 0, 1, 1};
    localparam int WARN_V = 2;

    logic clock = 1'b0;
    logic rst = 1'b1;
    logic [NC-1:0] push = '0;
    logic [NC-1:0] cancel = '0;

    logic [NC-1:0] light_o [NCFG];
    logic          any_o   [NCFG];
    logic [NC-1:0] warn_o  [NCFG];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: a lit channel stays lit through cycle last_lit[c][i].
    bit m_lit   [NCFG][NC];
    int last_lit[NCFG][NC];

    always #5 clock = ~clock;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        timer_light_array_if #(.N(NC)) bus ();
        timer_light_array #(
            .N      (NC),
            .W      (4),
            .T      (TV[g]),
`ifdef TIMER_LIGHT_WARN_EN
            .WARN   (WARN_V),
`endif
            .RETRIG (RV[g])
        ) dut (
            .clock (clock),
            .reset (rst),
            .bus   (bus.slave)
        );
        assign bus.push_btn = push;
        assign bus.cancel   = cancel;
        assign light_o[g]   = bus.light;
        assign any_o[g]     = bus.any_on;
`ifdef TIMER_LIGHT_WARN_EN
        assign warn_o[g]    = bus.warn;
`else
        assign warn_o[g]    = '0;
`endif
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Apply one edge of the specification's rules to the model; cyc is the cycle after the edge.
    task automatic model_edge(input logic [NC-1:0] p, input logic [NC-1:0] cn, input logic r);
        for (int c = 0; c < NCFG; c++) begin
            for (int i = 0; i < NC; i++) begin
                if (r) begin
                    m_lit[c][i]    = 1'b1;
                    last_lit[c][i] = cyc + TV[c];
                end else if (m_lit[c][i]) begin
                    if (cn[i])
                        m_lit[c][i] = 1'b0;
                    else if (p[i] && RV[c] == 1)
                        last_lit[c][i] = cyc + TV[c];
                    else if (last_lit[c][i] <= cyc - 1)
                        m_lit[c][i] = 1'b0;
                end else if (!cn[i] && p[i]) begin
                    m_lit[c][i]    = 1'b1;
                    last_lit[c][i] = cyc + TV[c];
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NCFG; c++) begin
            logic [NC-1:0] exp_l;
            logic [NC-1:0] exp_w;
            exp_l = '0;
            exp_w = '0;
            for (int i = 0; i < NC; i++) begin
                exp_l[i] = m_lit[c][i];
                exp_w[i] = m_lit[c][i] && ((last_lit[c][i] - cyc) < WARN_V);
            end
            check_val($sformatf("light_cfg%0d", c), 32'(light_o[c]), 32'(exp_l));
            check_val($sformatf("any_on_cfg%0d", c), 32'(any_o[c]), 32'(|exp_l));
`ifdef TIMER_LIGHT_WARN_EN
            check_val($sformatf("warn_cfg%0d", c), 32'(warn_o[c]), 32'(exp_w));
`endif
        end
    endtask

    task automatic step(input logic [NC-1:0] p, input logic [NC-1:0] cn, input logic r);
        push   = p;
        cancel = cn;
        rst    = r;
        @(posedge clock);
        cyc++;
        model_edge(p, cn, r);
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        logic [NC-1:0] rp;
        logic [NC-1:0] rc;
        logic          rr;

        // Reset, then idle until every configuration has expired.
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        for (int k = 0; k < 20; k++) step('0, '0, 1'b0);

        // Single-cycle push on channel 2.
        step(4'b0100, '0, 1'b0);
        for (int k = 0; k < 20; k++) step('0, '0, 1'b0);

        // Push channel 0 again just before expiry (retrigger vs. ignored).
        step(4'b0001, '0, 1'b0);
        for (int k = 0; k < 4; k++) step('0, '0, 1'b0);
        step(4'b0001, '0, 1'b0);
        for (int k = 0; k < 20; k++) step('0, '0, 1'b0);

        // Push and cancel together while ON, then while OFF.
        step(4'hF, '0, 1'b0);
        step(4'hF, 4'hF, 1'b0);
        step(4'hF, 4'hF, 1'b0);
        for (int k = 0; k < 3; k++) step('0, '0, 1'b0);

        // Held push on channel 3: stays lit with retrigger, one OFF gap per period without.
        for (int k = 0; k < 40; k++) step(4'b1000, '0, 1'b0);
        for (int k = 0; k < 20; k++) step('0, '0, 1'b0);

        // Reset in the middle of a countdown with pushes active.
        step(4'hF, '0, 1'b0);
        step('0, '0, 1'b0);
        step(4'hF, 4'b0010, 1'b1);
        for (int k = 0; k < 20; k++) step('0, '0, 1'b0);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            rp = '0;
            rc = '0;
            for (int i = 0; i < NC; i++) begin
                rp[i] = ($urandom_range(0, 7) == 0);
                rc[i] = ($urandom_range(0, 31) == 0);
            end
            rr = ($urandom_range(0, 199) == 0);
            step(rp, rc, rr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
